// File: rtl/fft16_in_buffer_if.sv
// fft16_in_buffer_if: handshake and data bundle for the 16-point FFT input buffer.
//
//   in_valid / in_ready / in_data / in_last : per-sample stream from upstream.
//                                             in_data = {real[33:17], imag[16:0]}.
//   frame_valid / frame_ready / frame_data  : whole-frame handoff to the butterfly
//                                             stage; frame_data lane k = bits 34k+33:34k.
//   frame_err                               : one-cycle short-frame pulse.
//
// Modports:
//   master : the environment (drives samples, accepts frames).
//   slave  : the buffer itself.
interface fft16_in_buffer_if;
  logic         in_valid;
  logic         in_ready;
  logic [33:0]  in_data;
  logic         in_last;
  logic         frame_valid;
  logic         frame_ready;
  logic [543:0] frame_data;
  logic         frame_err;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output frame_ready,
    input  in_ready,
    input  frame_valid,
    input  frame_data,
    input  frame_err
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  frame_ready,
    output in_ready,
    output frame_valid,
    output frame_data,
    output frame_err
  );
endinterface

// File: rtl/fft16_in_buffer.sv
// fft16_in_buffer: ping-pong buffer that collects 16 complex samples (34 bits each,
// {real[33:17], imag[16:0]}) and presents them as one 544-bit frame to a 16-point
// butterfly stage.
//
// Ports:
//   clk    : single clock, all state updates on its rising edge.
//   rst_n  : asynchronous active-low reset; clears both banks, flags and pointers.
//   bus    : fft16_in_buffer_if.slave
//            in_valid/in_ready/in_data/in_last  sample stream in
//            frame_valid/frame_ready/frame_data frame handoff out
//            frame_err                          short-frame pulse
//
// Optional feature (macro FFT16_LAST_CHECK_EN): in_last closes a frame early, the
// unwritten lanes read as zero and frame_err pulses; a frame reaching 16 samples
// without in_last also pulses frame_err. Without the macro in_last is ignored and
// frame_err is tied low.
module fft16_in_buffer (
  input logic              clk,
  input logic              rst_n,
  fft16_in_buffer_if.slave bus
);

  localparam int unsigned Lanes   = 16;
  localparam int unsigned SampleW = 34;
  localparam int unsigned FrameW  = Lanes * SampleW;
  localparam logic [3:0]  LastCnt = 4'd15;

  logic [FrameW-1:0] bank_q [2];
  logic [FrameW-1:0] bank_d [2];
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [3:0]        wr_cnt_q, wr_cnt_d;

  logic accept;
  logic release_frame;
  logic close_frame;
  logic zero_tail;

  // Handshakes
  assign bus.in_ready    = ~full_q[wr_bank_q];
  assign accept          = bus.in_valid & bus.in_ready;
  assign bus.frame_valid = full_q[rd_bank_q];
  assign release_frame   = bus.frame_valid & bus.frame_ready;
  assign bus.frame_data  = bank_q[rd_bank_q];

`ifdef FFT16_LAST_CHECK_EN
  logic frame_err_q, frame_err_d;

  // An early in_last closes the frame; reaching lane 15 always closes it.
  assign close_frame = accept & ((wr_cnt_q == LastCnt) | bus.in_last);
  // Lanes above the closing lane may hold a stale frame and must be cleared.
  assign zero_tail   = close_frame & (wr_cnt_q != LastCnt);
  // Error whenever in_last disagrees with the lane position.
  assign frame_err_d = accept & (bus.in_last ^ (wr_cnt_q == LastCnt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.frame_err = frame_err_q;
`else
  logic unused_in_last;

  assign close_frame    = accept & (wr_cnt_q == LastCnt);
  assign zero_tail      = 1'b0;
  assign unused_in_last = bus.in_last;
  assign bus.frame_err  = 1'b0;
`endif

  // Bank write: one lane per accepted sample, optional tail clear on an early close.
  always_comb begin
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    for (int b = 0; b < 2; b++) begin
      if (accept && (wr_bank_q == 1'(b))) begin
        for (int k = 0; k < Lanes; k++) begin
          if (wr_cnt_q == 4'(k)) begin
            bank_d[b][k*SampleW +: SampleW] = bus.in_data;
          end else if (zero_tail && (4'(k) > wr_cnt_q)) begin
            bank_d[b][k*SampleW +: SampleW] = '0;
          end
        end
      end
    end
  end

  // Pointer and flag next state. close_frame needs full[wr_bank]=0 and
  // release_frame needs full[rd_bank]=1, so on a shared edge they hit
  // different banks and both updates apply.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;

    if (release_frame) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end

    if (accept) begin
      if (close_frame) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0] <= '0;
      bank_q[1] <= '0;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  // Pointer invariants: with no bank full the pointers coincide, and with both
  // full the writer has wrapped onto the bank being read.
  a_ptr_empty: assert property (@(posedge clk) disable iff (!rst_n)
    (full_q == 2'b00) |-> (wr_bank_q == rd_bank_q));
  a_ptr_full: assert property (@(posedge clk) disable iff (!rst_n)
    (full_q == 2'b11) |-> (wr_bank_q == rd_bank_q && wr_cnt_q == 4'd0));
  a_ptr_one: assert property (@(posedge clk) disable iff (!rst_n)
    (full_q == 2'b01 || full_q == 2'b10) |-> (wr_bank_q != rd_bank_q));

endmodule

// File: tb/tb_fft16_in_buffer.sv
// Self-checking bench for fft16_in_buffer: per-cycle vector table for the
// backpressure and same-edge cases, directed sequences for the rest, and a frame
// scoreboard fed by a sample-level reference model.
module tb_fft16_in_buffer;

  logic clk;
  logic rst_n;

  fft16_in_buffer_if bus ();

  fft16_in_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  int pops     = 0;

  task automatic chk(input string name, input logic [543:0] act, input logic [543:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] mk(input int re, input int im);
    logic [16:0] r;
    logic [16:0] i;
    r = 17'(re);
    i = 17'(im);
    return {r, i};
  endfunction

  // Reference model and scoreboard, evaluated away from the active edge.
  logic [33:0]  part [16];
  int           part_cnt = 0;
  logic [543:0] exp_q [$];
  bit           err_pend = 1'b0;

  initial begin
    logic [543:0] f;
    bit close;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        part_cnt = 0;
        exp_q.delete();
        err_pend = 1'b0;
      end else begin
        chk("frame_err", 544'(bus.frame_err), 544'(err_pend));
        err_pend = 1'b0;
        if (bus.frame_valid && bus.frame_ready) begin
          if (exp_q.size() == 0) begin
            chk("frame_unexpected", 544'(bus.frame_valid), 544'(0));
          end else begin
            f = exp_q.pop_front();
            chk("frame_data", bus.frame_data, f);
          end
          pops++;
        end
        if (bus.in_valid && bus.in_ready) begin
          part[part_cnt] = bus.in_data;
          close = (part_cnt == 15);
`ifdef FFT16_LAST_CHECK_EN
          if (bus.in_last) close = 1'b1;
          err_pend = (bus.in_last != (part_cnt == 15));
`endif
          if (close) begin
            f = '0;
            for (int k = 0; k <= part_cnt; k++) f[k*34 +: 34] = part[k];
            exp_q.push_back(f);
            part_cnt = 0;
          end else begin
            part_cnt++;
          end
        end
      end
    end
  end

  // Per-cycle vector table: inputs held for one cycle, outputs checked mid-cycle.
  typedef struct {
    bit          do_reset;
    bit          valid;
    bit          ready;
    logic [33:0] data;
    bit          exp_in_ready;
    bit          exp_fv;
    logic [33:0] exp_lane0;
  } vec_t;

  vec_t vecs [$];

  task automatic add_vec(input bit rs, input bit v, input bit r, input int d,
                         input bit eir, input bit efv, input int el0);
    vec_t t;
    t.do_reset     = rs;
    t.valid        = v;
    t.ready        = r;
    t.data         = 34'(d);
    t.exp_in_ready = eir;
    t.exp_fv       = efv;
    t.exp_lane0    = 34'(el0);
    vecs.push_back(t);
  endtask

  task automatic apply_reset();
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.in_last     = 1'b0;
    bus.frame_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drive one sample and hold it until accepted (bounded).
  task automatic send(input logic [33:0] d, input bit last, input bit must_ready);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    @(negedge clk);
    if (must_ready) chk("in_ready_hold", 544'(bus.in_ready), 544'(1));
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("send_timeout", 544'(bus.in_ready), 544'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_pops(input int target);
    int t;
    t = 0;
    while (pops < target && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("frame_count", 544'(pops), 544'(target));
  endtask

  initial begin
    logic [33:0] lane5_exp;
    int base;

    // Backpressure: 32 samples fill both banks, the 33rd waits for a release.
    for (int c = 0; c < 32; c++) add_vec(c == 0, 1, 0, c, 1, c >= 16, 0);
    add_vec(0, 1, 0, 32, 0, 1, 0);
    add_vec(0, 1, 1, 32, 0, 1, 0);
    add_vec(0, 1, 0, 32, 1, 1, 16);
    add_vec(0, 0, 0, 0, 1, 1, 16);
    // Same edge: bank A released while bank B receives its 16th sample.
    for (int c = 0; c < 32; c++) add_vec(c == 0, 1, c == 31, 100 + c, 1, c >= 16, 100);
    add_vec(0, 0, 0, 0, 1, 1, 116);
    add_vec(0, 0, 1, 0, 1, 1, 116);
    add_vec(0, 0, 0, 0, 1, 0, 0);

    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.in_last     = 1'b0;
    bus.frame_ready = 1'b0;
    rst_n           = 1'b0;
    #1;
    apply_reset();

    // Reset values
    @(negedge clk);
    chk("rst_in_ready", 544'(bus.in_ready), 544'(1));
    chk("rst_frame_valid", 544'(bus.frame_valid), 544'(0));
    chk("rst_frame_data", bus.frame_data, 544'(0));
    chk("rst_frame_err", 544'(bus.frame_err), 544'(0));
    @(posedge clk);
    #1;

    // Basic frame: real=k, imag=-k with frame_ready high.
    base = pops;
    bus.frame_ready = 1'b1;
    for (int k = 0; k < 16; k++) send(mk(k, -k), 1'b0, 1'b1);
    @(negedge clk);
    chk("basic_frame_valid", 544'(bus.frame_valid), 544'(1));
    lane5_exp = {17'd5, 17'h1fffb};
    chk("basic_lane5", 544'(bus.frame_data[5*34 +: 34]), 544'(lane5_exp));
    wait_pops(base + 1);
    @(posedge clk);
    #1;

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_reset) apply_reset();
      bus.in_valid    = vecs[i].valid;
      bus.in_data     = vecs[i].data;
      bus.in_last     = 1'b0;
      bus.frame_ready = vecs[i].ready;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), 544'(bus.in_ready), 544'(vecs[i].exp_in_ready));
      chk($sformatf("vec%0d_frame_valid", i), 544'(bus.frame_valid), 544'(vecs[i].exp_fv));
      if (vecs[i].exp_fv)
        chk($sformatf("vec%0d_lane0", i), 544'(bus.frame_data[33:0]), 544'(vecs[i].exp_lane0));
      @(posedge clk);
      #1;
    end

    // Sustained streaming: 64 samples, no stalls, four frames.
    apply_reset();
    base = pops;
    bus.frame_ready = 1'b1;
    for (int k = 0; k < 64; k++) send(34'(k), 1'b0, 1'b1);
    wait_pops(base + 4);

    // Reset mid-stream discards a full frame and a partial one.
    apply_reset();
    for (int k = 0; k < 23; k++) send(34'(500 + k), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 544'(bus.in_ready), 544'(1));
    chk("midrst_frame_valid", 544'(bus.frame_valid), 544'(0));
    chk("midrst_frame_data", bus.frame_data, 544'(0));
    chk("midrst_frame_err", 544'(bus.frame_err), 544'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base = pops;
    bus.frame_ready = 1'b1;
    for (int k = 0; k < 16; k++) send(34'(600 + k), 1'b0, 1'b0);
    wait_pops(base + 1);

    // in_last on the 10th sample, written over a bank holding a stale frame.
    apply_reset();
    base = pops;
    bus.frame_ready = 1'b1;
    for (int k = 0; k < 32; k++) send(34'(1000 + k), 1'b0, 1'b0);
    wait_pops(base + 2);
    @(posedge clk);
    #1;
    bus.frame_ready = 1'b0;
    for (int k = 0; k < 10; k++) send(34'(300 + k), k == 9, 1'b0);
    @(negedge clk);
`ifdef FFT16_LAST_CHECK_EN
    chk("short_frame_valid", 544'(bus.frame_valid), 544'(1));
    chk("short_tail_zero", 544'(bus.frame_data[543:340]), 544'(0));
    chk("short_err_pulse", 544'(bus.frame_err), 544'(1));
    @(negedge clk);
    chk("short_err_clear", 544'(bus.frame_err), 544'(0));
`else
    chk("short_frame_valid", 544'(bus.frame_valid), 544'(0));
    chk("short_err_low", 544'(bus.frame_err), 544'(0));
    @(posedge clk);
    #1;
    for (int k = 10; k < 16; k++) send(34'(300 + k), 1'b0, 1'b0);
    @(negedge clk);
    chk("short_frame_full16", 544'(bus.frame_valid), 544'(1));
    chk("short_lane15", 544'(bus.frame_data[543:510]), 544'(315));
`endif
    @(posedge clk);
    #1;
    bus.frame_ready = 1'b1;
    wait_pops(base + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft16_in_buffer.md
FFT16_IN_BUFFER -- requirements
Module: fft16_in_buffer

Interface
REQ-001 The block SHALL have one parameter: none; frame size is fixed at 16 complex samples of 34 bits, {real[33:17], imag[16:0]}, signed two's complement.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream sample valid.
REQ-005 in_ready  output  1  block can accept a sample this cycle.
REQ-006 in_data  input  34  complex sample.
REQ-007 in_last  input  1  marks the final sample of a frame; used only when FFT16_LAST_CHECK_EN is defined.
REQ-008 frame_valid  output  1  a complete 16-sample frame is presented.
REQ-009 frame_ready  input  1  the downstream 16-point butterfly stage accepts the frame.
REQ-010 frame_data  output  544  lane k (bits 34k+33:34k) = k-th accepted sample of the frame, k=0..15.
REQ-011 frame_err  output  1  one-cycle pulse on a short-frame event.

Function
REQ-012 Storage SHALL be two 544-bit banks (ping-pong), each with a full flag, plus write-bank select wr_bank, read-bank select rd_bank and a 4-bit lane counter wr_cnt.
REQ-013 in_ready SHALL equal NOT full[wr_bank], combinationally.
REQ-014 A sample SHALL be accepted on a rising edge where in_valid AND in_ready; it is written to lane wr_cnt of bank wr_bank and wr_cnt increments.
REQ-015 On acceptance with wr_cnt=15, the block SHALL set full[wr_bank], toggle wr_bank and wrap wr_cnt to 0.
REQ-016 frame_valid SHALL equal full[rd_bank]; frame_data SHALL equal bank rd_bank, held stable while frame_valid is high and frame_ready is low.
REQ-017 On a rising edge where frame_valid AND frame_ready, the block SHALL clear full[rd_bank] and toggle rd_bank.
REQ-018 Latency: frame_valid SHALL rise in the cycle immediately after the edge that accepts the 16th sample (1 cycle).
REQ-019 A frame completing into one bank and a release of the other bank on the same edge SHALL both take effect; no sample is lost or duplicated.
REQ-020 With frame_ready held high, the block SHALL sustain one sample per cycle indefinitely with in_ready never low.
REQ-021 With both banks full, in_ready SHALL be low; it SHALL rise in the cycle after the release edge.
REQ-022 A bank release while the same bank is partially written is impossible by construction; wr_bank and rd_bank SHALL differ only while exactly one bank is full or one bank is being filled ahead.

Reset
REQ-023 On rst_n low, the block SHALL asynchronously clear wr_cnt, wr_bank, rd_bank, both full flags, both banks and frame_err.
REQ-024 Reset values: in_ready=1, frame_valid=0, frame_data=0, frame_err=0.
REQ-025 A reset mid-frame SHALL discard the partial frame and any full frames; the first sample after release of rst_n goes to lane 0 of bank 0.

Configuration
REQ-026 Macro FFT16_LAST_CHECK_EN: when defined, an accepted sample with in_last=1 and wr_cnt<15 SHALL close the frame as in REQ-015, with lanes wr_cnt+1..15 of that frame read as zero, and SHALL pulse frame_err for one cycle on the following cycle.
REQ-027 When defined, in_last=1 at wr_cnt=15 SHALL be normal, and in_last=0 at wr_cnt=15 SHALL also complete the frame and pulse frame_err.
REQ-028 When FFT16_LAST_CHECK_EN is not defined, in_last SHALL be ignored and frame_err SHALL be tied to 0.

Verification
REQ-029 Reset, then feed samples real=k, imag=-k for k=0..15 back-to-back with frame_ready=1 -> frame_valid high one cycle after the 16th acceptance; lane 5 = {17'd5, -17'd5}; in_ready stays 1.
REQ-030 frame_ready=0, feed 32 samples then 1 more -> in_ready low after the 32nd; frame_valid high; frame_data holds frame 0; the 33rd sample is not accepted until frame_ready is pulsed, then in_ready=1 next cycle.
REQ-031 Continuous 64 samples (value = index) with frame_ready=1 -> four frames whose lane 0 values are 0, 16, 32, 48; no stall cycles.
REQ-032 Same-edge case: bank A full, 16th sample of bank B accepted on the edge frame_ready=1 -> A released, B full, frame_valid stays high, frame_data switches to B the next cycle.
REQ-033 Assert rst_n low after 7 samples -> all outputs at reset values immediately; next 16 samples form a frame starting at lane 0.
REQ-034 With FFT16_LAST_CHECK_EN: in_last=1 on 10th sample -> frame_valid next cycle, lanes 10..15 = 0, frame_err one-cycle pulse; without the macro: same stimulus -> frame completes only after 16 samples, frame_err=0.
